// File: rtl/dot_accumulator_if.sv
// Product-in / sum-out handshake bundle for dot_accumulator.
// Widths are derived from N and PW so that every user agrees on AW and the idx width.
interface dot_accumulator_if #(
   parameter int N  = 4,
   parameter int PW = 16
);
   localparam int AW = PW + $clog2(N);
   localparam int IW = $clog2(N) + 1;

   logic          prod_valid;
   logic          prod_ready;
   logic [PW-1:0] prod;
   logic          sum_valid;
   logic          sum_ready;
   logic [AW-1:0] sum;
   logic [IW-1:0] idx;

   modport master (
      output prod_valid, prod, sum_ready,
      input  prod_ready, sum_valid, sum, idx
   );

   modport slave (
      input  prod_valid, prod, sum_ready,
      output prod_ready, sum_valid, sum, idx
   );
endinterface

// File: rtl/dot_accumulator.sv
// Sums exactly N unsigned products into one dot-product element and holds it
// until the consumer takes it; clear aborts the vector in progress.
module dot_accumulator #(
   parameter int N  = 4,
   parameter int PW = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   dot_accumulator_if.slave bus
);
   localparam int AW = PW + $clog2(N);
   localparam int IW = $clog2(N) + 1;

   typedef enum logic {ACC, DONE} state_t;

   state_t        state;
   state_t        state_next;
   logic [AW-1:0] acc;
   logic [AW-1:0] addend_sum;
   logic [AW-1:0] sum_r;
   logic [IW-1:0] idx_r;
   logic          accept;
   logic          last;

   assign bus.sum_valid = (state == DONE);
   assign bus.sum       = sum_r;
   assign bus.idx       = idx_r;

   always_comb begin
      bus.prod_ready = (state == ACC) && !clear;
      accept         = bus.prod_valid && bus.prod_ready;
      last           = (idx_r == IW'(N - 1));
      // The first product of a vector overwrites acc, so acc never needs clearing on completion.
      addend_sum     = (idx_r == '0) ? AW'(bus.prod) : acc + AW'(bus.prod);
      state_next     = state;
      if (clear) begin
         state_next = ACC;
      end else begin
         case (state)
            ACC:     if (accept && last) state_next = DONE;
            DONE:    if (bus.sum_ready)  state_next = ACC;
            default: state_next = ACC;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ACC;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         idx_r <= '0;
         sum_r <= '0;
      end else if (clear) begin
         acc   <= '0;
         idx_r <= '0;
      end else if (accept) begin
         if (last) begin
            sum_r <= addend_sum;
            idx_r <= '0;
         end else begin
            acc   <= addend_sum;
            idx_r <= idx_r + IW'(1);
         end
      end
   end
endmodule

// File: tb/tb_dot_accumulator.sv
// Randomized bench for dot_accumulator (N=4 and N=1) against a queue-based
// model of "collect N products, present their sum, wait for the taker".
module tb_dot_accumulator;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   logic clr;
   logic clr1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   dot_accumulator_if #(.N(4), .PW(16)) bus ();
   dot_accumulator_if #(.N(1), .PW(16)) bus1 ();

   dot_accumulator #(.N(4), .PW(16)) dut  (.clk(clk), .rst(rst), .clear(clr),  .bus(bus));
   dot_accumulator #(.N(1), .PW(16)) dut1 (.clk(clk), .rst(rst), .clear(clr1), .bus(bus1));

   wire [22:0] obs  = {bus.prod_ready, bus.sum_valid, bus.idx, bus.sum};
   wire [18:0] obs1 = {bus1.prod_ready, bus1.sum_valid, bus1.idx, bus1.sum};

   // Model: products collected so far in this vector, whether a result is held, last result.
   logic [15:0] q[$];
   bit          m_hold;
   logic [17:0] m_sum;

   function automatic logic [22:0] exp_vec();
      logic [2:0] n;
      n = 3'(q.size());
      return {!m_hold && !clr, m_hold, n, m_sum};
   endfunction

   task automatic m_reset();
      q.delete();
      m_hold = 1'b0;
      m_sum  = '0;
   endtask

   task automatic tick(output bit took);
      bit xfer;
      int s;
      took = !m_hold && !clr && (bus.prod_valid === 1'b1);
      xfer = m_hold && (bus.sum_ready === 1'b1);
      @(posedge clk);
      if (clr) begin
         q.delete();
         m_hold = 1'b0;
      end else if (took) begin
         q.push_back(bus.prod);
         if (q.size() == N) begin
            s = 0;
            foreach (q[i]) s += int'(q[i]);
            m_sum  = 18'(s);
            m_hold = 1'b1;
            q.delete();
         end
      end else if (xfer) begin
         m_hold = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      bus.prod_valid = 1'b0;
      bus.sum_ready  = 1'b0;
      clr            = 1'b0;
      rst            = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_reset();
   endtask

   task automatic test_reset();
      bus.prod_valid  = 1'b0; bus.sum_ready  = 1'b0; bus.prod  = '0;
      bus1.prod_valid = 1'b0; bus1.sum_ready = 1'b0; bus1.prod = '0;
      clr = 1'b0; clr1 = 1'b0;
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (obs !== 23'h400000) begin
         bad++; $display("FAIL reset_n4 got=%h want=%h", obs, 23'h400000);
      end
      total++;
      if (obs1 !== 19'h40000) begin
         bad++; $display("FAIL reset_n1 got=%h want=%h", obs1, 19'h40000);
      end
      rst = 1'b0;
      m_reset();
   endtask

   task automatic test_full_scale();
      bit took;
      int left = 8;
      int vcnt = 0;
      do_reset();
      bus.sum_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         bus.prod_valid = (left > 0);
         bus.prod       = 16'd65025;
         #1;
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL full_scale c=%0d got=%h want=%h", c, obs, exp_vec());
         end
         if (c < 7 && bus.sum_valid === 1'b1) begin
            vcnt++;
            total++;
            if (bus.sum !== 18'h3F804) begin
               bad++; $display("FAIL full_scale_sum got=%0d want=%0d", bus.sum, 260100);
            end
         end
         tick(took);
         if (took) left--;
      end
      total++;
      if (vcnt != 1) begin
         bad++; $display("FAIL full_scale_valid_cycles got=%0d want=1", vcnt);
      end
   endtask

   task automatic test_backpressure();
      bit took;
      logic [15:0] pq[$] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd7};
      int held = 0;
      do_reset();
      for (int c = 0; c < 12; c++) begin
         bus.prod_valid = (pq.size() > 0);
         bus.prod       = (pq.size() > 0) ? pq[0] : 16'($urandom);
         bus.sum_ready  = (held >= 5);
         #1;
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL backpressure c=%0d got=%h want=%h", c, obs, exp_vec());
         end
         if (m_hold) held++;
         tick(took);
         if (took) void'(pq.pop_front());
      end
      bus.prod_valid = 1'b0;
      total++;
      if (bus.idx !== 3'd1 || bus.sum !== 18'd10) begin
         bad++; $display("FAIL backpressure_next got idx=%0d sum=%0d want idx=1 sum=10", bus.idx, bus.sum);
      end
   endtask

   task automatic test_bursty();
      bit took;
      logic [15:0] pq[$] = '{16'd100, 16'd0, 16'd7, 16'd65535};
      int gap = 0;
      do_reset();
      bus.sum_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         bus.prod_valid = (pq.size() > 0) && (gap == 0);
         bus.prod       = bus.prod_valid ? pq[0] : 16'($urandom);
         #1;
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL bursty c=%0d got=%h want=%h", c, obs, exp_vec());
         end
         tick(took);
         if (took) begin
            void'(pq.pop_front());
            gap = int'($urandom_range(1, 3));
         end else if (gap > 0) begin
            gap--;
         end
      end
      total++;
      if (bus.sum !== 18'd65642) begin
         bad++; $display("FAIL bursty_sum got=%0d want=65642", bus.sum);
      end
   endtask

   task automatic test_clear();
      bit took;
      logic [15:0] pq[$] = '{16'd5, 16'd6};
      do_reset();
      bus.sum_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c == 2) begin
            clr = 1'b1;
            bus.prod_valid = 1'b1;
            bus.prod       = 16'd9;
            pq = '{16'd1, 16'd1, 16'd1, 16'd1};
         end else begin
            clr = 1'b0;
            bus.prod_valid = (pq.size() > 0);
            bus.prod       = bus.prod_valid ? pq[0] : 16'($urandom);
         end
         #1;
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL clear_mid c=%0d got=%h want=%h", c, obs, exp_vec());
         end
         tick(took);
         if (took && c != 2) void'(pq.pop_front());
      end
      total++;
      if (bus.sum !== 18'd4) begin
         bad++; $display("FAIL clear_mid_sum got=%0d want=4", bus.sum);
      end
      // Clear together with sum_ready while a result is held: the result is dropped.
      pq = '{16'd3, 16'd3, 16'd3, 16'd3};
      bus.sum_ready = 1'b0;
      for (int c = 0; c < 7; c++) begin
         clr = (c == 5);
         bus.sum_ready  = (c == 5);
         bus.prod_valid = (pq.size() > 0);
         bus.prod       = bus.prod_valid ? pq[0] : 16'($urandom);
         #1;
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL clear_done c=%0d got=%h want=%h", c, obs, exp_vec());
         end
         tick(took);
         if (took) void'(pq.pop_front());
      end
      clr = 1'b0;
   endtask

   task automatic test_async_reset();
      bit took;
      logic [15:0] pq[$];
      do_reset();
      for (int phase = 0; phase < 3; phase++) begin
         pq.delete();
         for (int k = 0; k < ((phase == 0) ? 3 : 4); k++)
            pq.push_back((phase == 2) ? 16'd2 : 16'($urandom));
         for (int c = 0; c < 6; c++) begin
            bus.prod_valid = (pq.size() > 0);
            bus.prod       = bus.prod_valid ? pq[0] : 16'($urandom);
            bus.sum_ready  = (phase == 2);
            #1;
            total++;
            if (obs !== exp_vec()) begin
               bad++; $display("FAIL async_reset p=%0d c=%0d got=%h want=%h", phase, c, obs, exp_vec());
            end
            tick(took);
            if (took) void'(pq.pop_front());
         end
         if (phase < 2) begin
            bus.prod_valid = 1'b0;
            #2 rst = 1'b1;
            #1;
            total++;
            if (obs !== 23'h400000) begin
               bad++; $display("FAIL async_reset_now p=%0d got=%h want=%h", phase, obs, 23'h400000);
            end
            m_reset();
            @(posedge clk);
            #1 rst = 1'b0;
         end
      end
      total++;
      if (bus.sum !== 18'd8) begin
         bad++; $display("FAIL async_reset_sum got=%0d want=8", bus.sum);
      end
   endtask

   task automatic test_random();
      bit took;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         bus.prod_valid = ($urandom_range(0, 99) < 70);
         bus.prod       = 16'($urandom);
         bus.sum_ready  = ($urandom_range(0, 99) < 60);
         clr            = ($urandom_range(0, 99) < 3);
         #1;
         total++;
         if (obs !== exp_vec()) begin
            bad++; $display("FAIL random c=%0d got=%h want=%h", c, obs, exp_vec());
         end
         tick(took);
      end
      clr = 1'b0;
   endtask

   task automatic test_degenerate();
      bus1.sum_ready  = 1'b1;
      bus1.prod_valid = 1'b1;
      bus1.prod       = 16'd300;
      #1;
      total++;
      if (obs1 !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
         bad++; $display("FAIL n1_idle got=%h want=%h", obs1, {1'b1, 1'b0, 1'b0, 16'd0});
      end
      @(posedge clk);
      #1;
      bus1.prod = 16'd65535;
      total++;
      if (obs1 !== {1'b0, 1'b1, 1'b0, 16'd300}) begin
         bad++; $display("FAIL n1_first got=%h want=%h", obs1, {1'b0, 1'b1, 1'b0, 16'd300});
      end
      @(posedge clk);
      #1;
      total++;
      if (obs1 !== {1'b1, 1'b0, 1'b0, 16'd300}) begin
         bad++; $display("FAIL n1_xfer got=%h want=%h", obs1, {1'b1, 1'b0, 1'b0, 16'd300});
      end
      @(posedge clk);
      #1;
      bus1.prod_valid = 1'b0;
      total++;
      if (obs1 !== {1'b0, 1'b1, 1'b0, 16'd65535}) begin
         bad++; $display("FAIL n1_second got=%h want=%h", obs1, {1'b0, 1'b1, 1'b0, 16'd65535});
      end
   endtask

   initial begin
      rst = 1'b0;
      test_reset();
      test_full_scale();
      test_backpressure();
      test_bursty();
      test_clear();
      test_async_reset();
      test_random();
      test_degenerate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
